// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the LEGv8 datapath: fetch/decode/exec/mem/wb
// with ack handshakes to instruction and data memory and a sticky timeout fault.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        regwrite,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        retired,
  output logic        mem_fault,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_ALU  = 3'd1,
    C_B    = 3'd2,
    C_CBZ  = 3'd3,
    C_LDUR = 3'd4,
    C_STUR = 3'd5
  } class_t;

  state_t           r_state;
  class_t           r_class;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_inc;
  logic             w_timeout;

  // ALU-reg, ALU-imm and MOVZ all take the same EXEC -> WB path.
  function automatic class_t decode_class(input logic [10:0] op);
    class_t cls;
    casez (op)
      11'b10001010000, 11'b10101010000,
      11'b10001011000, 11'b11001011000,
      11'b1001000100?, 11'b1101000100?,
      11'b110100101??: cls = C_ALU;
      11'b000101?????: cls = C_B;
      11'b10110100???: cls = C_CBZ;
      11'b11111000010: cls = C_LDUR;
      11'b11111000000: cls = C_STUR;
      default:         cls = C_NOP;
    endcase
    return cls;
  endfunction

  assign w_wait_inc = r_wait + CNT_W'(1);
  assign w_timeout  = (w_wait_inc == CNT_W'(MEM_TIMEOUT));

  // An ack in the limit cycle is checked first, so it always beats the timeout.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_class <= C_NOP;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_wait  <= w_wait_inc;
          end
        end
        S_DECODE: begin
          r_class <= decode_class(opcode);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_wait <= '0;
          case (r_class)
            C_LDUR, C_STUR: r_state <= S_MEM;
            C_ALU:          r_state <= S_WB;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_state <= (r_class == C_LDUR) ? S_WB : S_FETCH;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_FAULT;
          end else begin
            r_wait  <= w_wait_inc;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_wait  <= '0;
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by Reset so they drop the moment Reset rises.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    regwrite   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_fault  = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        S_EXEC: begin
          case (r_class)
            C_B: begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end
            C_CBZ: begin
              pc_write = 1'b1;
              pc_src   = zero;
            end
            C_NOP:   pc_write = 1'b1;
            default: pc_write = 1'b0;
          endcase
        end
        S_MEM: begin
          dmem_read  = (r_class == C_LDUR);
          dmem_write = (r_class == C_STUR);
          pc_write   = dmem_ack && (r_class == C_STUR);
        end
        S_WB: begin
          regwrite = 1'b1;
          pc_write = 1'b1;
        end
        S_FAULT: mem_fault = 1'b1;
        default: mem_fault = 1'b0;
      endcase
    end
  end

  assign retired = pc_write;
  assign state   = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed corner cases plus random instruction
// streams checked cycle by cycle against a table-driven instruction model.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 15;
  localparam int K_NOP = 0, K_ALU = 1, K_B = 2, K_CBZ = 3, K_LD = 4, K_ST = 5;
  localparam int NPAT = 11;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b00010111010;
  localparam logic [10:0] OP_MOVZ = 11'b11010010110;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;

  logic        Clk, Reset, zero, imem_ack, dmem_ack;
  logic [10:0] opcode;
  logic        imem_req, ir_write, pc_write, pc_src, regwrite;
  logic        dmem_read, dmem_write, retired, mem_fault;
  logic [2:0]  state;
  logic [11:0] obs;
  int          n_tests, n_fail;

  logic [10:0] pat_val [NPAT];
  logic [10:0] pat_dc  [NPAT];
  int          pat_cls [NPAT];

  multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .regwrite(regwrite), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .retired(retired), .mem_fault(mem_fault),
    .state(state)
  );

  assign obs = {state, imem_req, ir_write, pc_write, pc_src, regwrite,
                dmem_read, dmem_write, retired, mem_fault};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
               tag, got[11:9], got[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  // Expected observation; retired always mirrors pc_write.
  function automatic logic [11:0] ex(input int st, input logic ireq, input logic ir,
                                     input logic pcw, input logic pcs, input logic rw,
                                     input logic rd, input logic wr, input logic flt);
    return {3'(st), ireq, ir, pcw, pcs, rw, rd, wr, pcw, flt};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [10:0] ro();
    return 11'($urandom);
  endfunction

  function automatic int cls(input logic [10:0] op);
    for (int i = 0; i < NPAT; i++)
      if ((op & ~pat_dc[i]) == pat_val[i]) return pat_cls[i];
    return K_NOP;
  endfunction

  function automatic logic [10:0] rand_op();
    int k;
    k = $urandom_range(0, NPAT);
    if (k == NPAT) return ro();
    return pat_val[k] | (ro() & pat_dc[k]);
  endfunction

  // One clock: drive inputs on the falling edge, then sample outputs.
  task automatic cyc(input string tag, input logic ia, input logic da,
                     input logic [10:0] op, input logic z, input logic [11:0] exp);
    @(negedge Clk);
    imem_ack = ia;
    dmem_ack = da;
    opcode   = op;
    zero     = z;
    #1 check(tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = ro(); zero = rb();
    #1 check("in_reset", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    #1 check("in_reset_hold", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0; imem_ack = 1'b0; dmem_ack = rb();
    #1 check("post_reset", obs, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Opcode is only meaningful in DECODE and zero only in EXEC; both are noise elsewhere.
  task automatic run_instr(input logic [10:0] op, input logic z, input int fw, input int dw);
    int k;
    k = cls(op);
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", 1'b0, rb(), ro(), rb(), ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("fetch_ack", 1'b1, rb(), ro(), rb(), ex(0, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc("decode", rb(), rb(), op, rb(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
    case (k)
      K_B:     cyc("exec_b",   rb(), rb(), ro(), z, ex(2, 0, 0, 1, 1, 0, 0, 0, 0));
      K_CBZ:   cyc("exec_cbz", rb(), rb(), ro(), z, ex(2, 0, 0, 1, z, 0, 0, 0, 0));
      K_NOP:   cyc("exec_nop", rb(), rb(), ro(), z, ex(2, 0, 0, 1, 0, 0, 0, 0, 0));
      default: cyc("exec",     rb(), rb(), ro(), z, ex(2, 0, 0, 0, 0, 0, 0, 0, 0));
    endcase
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < dw; i++)
        cyc("mem_wait", rb(), 1'b0, ro(), rb(),
            ex(3, 0, 0, 0, 0, 0, k == K_LD, k == K_ST, 0));
      cyc("mem_ack", rb(), 1'b1, ro(), rb(),
          ex(3, 0, 0, k == K_ST, 0, 0, k == K_LD, k == K_ST, 0));
    end
    if (k == K_ALU || k == K_LD)
      cyc("wb", rb(), rb(), ro(), rb(), ex(4, 0, 0, 1, 0, 1, 0, 0, 0));
  endtask

  initial begin
    int fw, dw;
    n_tests = 0;
    n_fail  = 0;
    Reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; opcode = '0;

    pat_val = '{11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000,
                11'b10010001000, 11'b11010001000, 11'b11010010100, 11'b00010100000,
                11'b10110100000, 11'b11111000010, 11'b11111000000};
    pat_dc  = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h001, 11'h001, 11'h003,
                11'h01F, 11'h007, 11'h000, 11'h000};
    pat_cls = '{K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU,
                K_B, K_CBZ, K_LD, K_ST};

    #1 check("reset_state", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_CBZ, 1'b1, 0, 0);
    run_instr(OP_CBZ, 1'b0, 0, 0);
    run_instr(OP_LDUR, 1'b0, 0, 3);
    run_instr(11'b00000000000, 1'b1, 2, 0);
    run_instr(OP_STUR, 1'b0, 1, 0);
    run_instr(OP_B, 1'b0, 0, 0);
    run_instr(OP_MOVZ, 1'b1, 3, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_LDUR, 1'b0, 0, 14);

    // Acks arriving exactly on the timeout cycle must still be accepted.
    do_reset();
    run_instr(OP_LDUR, 1'b1, 13, 14);

    // Instruction memory never answers: fifteen waiting FETCH cycles, then FAULT.
    do_reset();
    for (int i = 0; i < int'(TO) - 1; i++)
      cyc("imem_wait", 1'b0, rb(), ro(), rb(), ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("imem_fault", 1'b0, rb(), ro(), rb(), ex(7, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (5) cyc("fault_sticky", rb(), rb(), ro(), rb(), ex(7, 0, 0, 0, 0, 0, 0, 0, 1));

    // Data memory never answers a load.
    do_reset();
    run_instr(OP_B, 1'b0, 0, 0);
    cyc("fetch_ack", 1'b1, 1'b0, ro(), rb(), ex(0, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc("decode", 1'b0, 1'b0, OP_LDUR, rb(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("exec", rb(), 1'b0, ro(), rb(), ex(2, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < int'(TO); i++)
      cyc("dmem_wait", rb(), 1'b0, ro(), rb(), ex(3, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc("dmem_fault", rb(), rb(), ro(), rb(), ex(7, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc("fault_sticky", rb(), rb(), ro(), rb(), ex(7, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset pulse in the middle of a store's MEM phase.
    do_reset();
    cyc("fetch_ack", 1'b1, 1'b0, ro(), rb(), ex(0, 1, 1, 0, 0, 0, 0, 0, 0));
    cyc("decode", 1'b0, 1'b0, OP_STUR, rb(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("exec", 1'b0, 1'b0, ro(), rb(), ex(2, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("stur_wait", 1'b0, 1'b0, ro(), rb(), ex(3, 0, 0, 0, 0, 0, 0, 1, 0));
    @(posedge Clk);
    #2 Reset = 1'b1; dmem_ack = 1'b1;
    #1 check("reset_mid_mem", obs, ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 check("restart_fetch", obs, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    run_instr(OP_ADD, 1'b0, 0, 0);

    repeat (60) begin
      fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 4));
      run_instr(rand_op(), rb(), fw, dw);
    end
    cyc("final_fetch", 1'b0, 1'b0, ro(), rb(), ex(0, 1, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
